pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 160, width of the payload that is zeroed on flush (instr, PC8, RS, RT, EXT).
REQ-002 SHALL have parameter KEEP_W, default 32, width of the field preserved on flush (PC4).
REQ-003 SHALL have parameter CTRL_W, default 8, width of the control bits zeroed on flush (RegW and similar).
REQ-004 SHALL have parameter DEPTH, default 1, legal range 1..4, number of chained register stages.
REQ-005 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port stall, input, 1, hold all stages.
REQ-008 SHALL have port clr, input, 1, insert a bubble into stage 0.
REQ-009 SHALL have port valid_D, input, 1, upstream slot holds a real instruction.
REQ-010 SHALL have ports data_D input DATA_W, keep_D input KEEP_W, and ctrl_D input CTRL_W, carrying the upstream payload.
REQ-011 SHALL have ports data_E output DATA_W, keep_E output KEEP_W, ctrl_E output CTRL_W, and valid_E output 1, taken from the last stage.
REQ-012 SHALL have port bubble_E, output, 1, high when the last stage holds a flushed or invalid slot (equal to ~valid_E).

Function
REQ-013 Priority per edge SHALL be reset > stall > clr > load.
REQ-014 On load, stage 0 SHALL capture {valid_D, data_D, keep_D, ctrl_D}, and stage k SHALL capture stage k-1 for k = 1..DEPTH-1.
REQ-015 On clr without stall, stage 0 SHALL capture valid=0, data=0, ctrl=0, keep=keep_D; the downstream stages SHALL shift as on load.
REQ-016 On stall, every stage SHALL hold its contents; a clr asserted in the same cycle SHALL be ignored, and upstream re-asserts it.
REQ-017 Latency from input to outputs SHALL be exactly DEPTH cycles with no stall asserted; each stall cycle SHALL add one cycle.
REQ-018 Outputs SHALL be driven directly from last-stage flops, with no combinational path from any input to any output.
REQ-019 With valid_D=0 and no clr, the payload SHALL still be captured as given, and only the valid bit SHALL mark the slot as invalid.
REQ-020 Continuous stall SHALL hold outputs indefinitely without corruption.

Reset
REQ-021 While reset is high at an edge, all stages SHALL clear valid, data, keep and ctrl to 0, overriding stall and clr.
REQ-022 After reset, data_E, keep_E, ctrl_E and valid_E SHALL be 0 and bubble_E SHALL be 1.
REQ-023 Reset mid-stream SHALL discard all in-flight slots; loading SHALL resume at the first edge with reset low.
REQ-024 All flops SHALL also power up to the reset values so simulation starts defined before the first reset.

Configuration
REQ-025 With macro PIPE_STAGE_PERF_EN defined, the block SHALL add outputs stall_cnt [31:0] and flush_cnt [31:0], counting edges where stall=1, and edges where clr=1 and stall=0, respectively.
REQ-026 These counters SHALL saturate at 32'hFFFFFFFF and SHALL clear on reset.
REQ-027 Without PIPE_STAGE_PERF_EN, the counter ports and their logic SHALL be absent, and the rest of the behaviour SHALL be identical.

Verification
REQ-028 DEPTH=1, load data_D=0xA5.., keep_D=0x00400004, ctrl_D=0x01, valid_D=1 -> the same values appear at the outputs one edge later, with bubble_E=0.
REQ-029 DEPTH=1, clr=1 with keep_D=0x00400010 and ctrl_D=0xFF -> data_E=0, ctrl_E=0, valid_E=0, keep_E=0x00400010, bubble_E=1.
REQ-030 DEPTH=3, stall=1 for 2 cycles in mid-stream -> the output sequence is unchanged and the first word arrives at cycle 5 instead of 3.
REQ-031 stall=1 and clr=1 on the same edge -> all outputs hold their previous values, and with PERF_EN stall_cnt increments while flush_cnt does not.
REQ-032 reset=1 together with stall=1 while DEPTH=2 is full -> all outputs are 0 and bubble_E=1 on the next edge; the first load after that appears 2 cycles later.
REQ-033 PERF_EN with stall_cnt preloaded to 0xFFFFFFFE and 3 stall cycles -> stall_cnt remains at 0xFFFFFFFF.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: a chain of DEPTH pipeline register stages between two
// processor stages. The chain supports stall (hold every stage) and clr
// (insert a bubble at stage 0). A bubble zeroes the payload and control
// bits but keeps the PC+4 field. Optional performance counters are
// compiled in when the macro PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int DATA_W = 160,
    parameter int KEEP_W = 32,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 1     // legal range 1..4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              clr,
    input  logic              valid_D,
    input  logic [DATA_W-1:0] data_D,
    input  logic [KEEP_W-1:0] keep_D,
    input  logic [CTRL_W-1:0] ctrl_D,
    output logic [DATA_W-1:0] data_E,
    output logic [KEEP_W-1:0] keep_E,
    output logic [CTRL_W-1:0] ctrl_E,
    output logic              valid_E,
    output logic              bubble_E
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    // Stage storage. The declaration initialisers give the power-up state,
    // which matches the reset state, so simulation is defined before reset.
    logic              valid_q [DEPTH] = '{default: 1'b0};
    logic [DATA_W-1:0] data_q  [DEPTH] = '{default: '0};
    logic [KEEP_W-1:0] keep_q  [DEPTH] = '{default: '0};
    logic [CTRL_W-1:0] ctrl_q  [DEPTH] = '{default: '0};

    logic              valid_d [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];
    logic [KEEP_W-1:0] keep_d  [DEPTH];
    logic [CTRL_W-1:0] ctrl_d  [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // Stage 0 next state: stall holds, clr inserts a bubble that
                // still carries the upstream PC+4, otherwise load upstream.
                always_comb begin
                    valid_d[0] = valid_q[0];
                    data_d[0]  = data_q[0];
                    keep_d[0]  = keep_q[0];
                    ctrl_d[0]  = ctrl_q[0];
                    if (!stall) begin
                        if (clr) begin
                            valid_d[0] = 1'b0;
                            data_d[0]  = '0;
                            keep_d[0]  = keep_D;
                            ctrl_d[0]  = '0;
                        end else begin
                            valid_d[0] = valid_D;
                            data_d[0]  = data_D;
                            keep_d[0]  = keep_D;
                            ctrl_d[0]  = ctrl_D;
                        end
                    end
                end
            end else begin : g_tail
                // Later stages next state: hold on stall, else shift from the
                // previous stage (clr only affects stage 0).
                always_comb begin
                    valid_d[gi] = valid_q[gi];
                    data_d[gi]  = data_q[gi];
                    keep_d[gi]  = keep_q[gi];
                    ctrl_d[gi]  = ctrl_q[gi];
                    if (!stall) begin
                        valid_d[gi] = valid_q[gi-1];
                        data_d[gi]  = data_q[gi-1];
                        keep_d[gi]  = keep_q[gi-1];
                        ctrl_d[gi]  = ctrl_q[gi-1];
                    end
                end
            end

            // Stage register: reset overrides stall and clr.
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q[gi] <= 1'b0;
                    data_q[gi]  <= '0;
                    keep_q[gi]  <= '0;
                    ctrl_q[gi]  <= '0;
                end else begin
                    valid_q[gi] <= valid_d[gi];
                    data_q[gi]  <= data_d[gi];
                    keep_q[gi]  <= keep_d[gi];
                    ctrl_q[gi]  <= ctrl_d[gi];
                end
            end
        end
    endgenerate

    // Outputs come straight from the last stage flops.
    assign data_E   = data_q[DEPTH-1];
    assign keep_E   = keep_q[DEPTH-1];
    assign ctrl_E   = ctrl_q[DEPTH-1];
    assign valid_E  = valid_q[DEPTH-1];
    assign bubble_E = ~valid_q[DEPTH-1];

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q = '0;
    logic [31:0] flush_cnt_q = '0;

    // Saturating event counters: stalled edges, and clr edges that actually
    // inserted a bubble (clr under stall is dropped and not counted).
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (clr && !stall && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: three instances (DEPTH 1, 2, 3) share one
// randomized stimulus stream. The stimulus side pushes each slot entering
// the pipe into a per-instance queue; the monitor pops one slot per
// advancing edge and compares it with the outputs.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic         valid;
        logic [159:0] data;
        logic [31:0]  keep;
        logic [7:0]   ctrl;
    } slot_t;

    logic         clk = 1'b0;
    logic         reset, stall, clr, valid_D;
    logic [159:0] data_D;
    logic [31:0]  keep_D;
    logic [7:0]   ctrl_D;

    logic [159:0] data_E1, data_E2, data_E3;
    logic [31:0]  keep_E1, keep_E2, keep_E3;
    logic [7:0]   ctrl_E1, ctrl_E2, ctrl_E3;
    logic         valid_E1, valid_E2, valid_E3;
    logic         bubble_E1, bubble_E2, bubble_E3;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]  stall_cnt1, flush_cnt1, stall_cnt2, flush_cnt2, stall_cnt3, flush_cnt3;
`endif

    int checks = 0;
    int errors = 0;

    slot_t q1[$], q2[$], q3[$];
    slot_t last1, last2, last3;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .stall(stall), .clr(clr), .valid_D(valid_D),
        .data_D(data_D), .keep_D(keep_D), .ctrl_D(ctrl_D),
        .data_E(data_E1), .keep_E(keep_E1), .ctrl_E(ctrl_E1),
        .valid_E(valid_E1), .bubble_E(bubble_E1)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
    );
    pipe_stage_reg #(.DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .stall(stall), .clr(clr), .valid_D(valid_D),
        .data_D(data_D), .keep_D(keep_D), .ctrl_D(ctrl_D),
        .data_E(data_E2), .keep_E(keep_E2), .ctrl_E(ctrl_E2),
        .valid_E(valid_E2), .bubble_E(bubble_E2)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
`endif
    );
    pipe_stage_reg #(.DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset), .stall(stall), .clr(clr), .valid_D(valid_D),
        .data_D(data_D), .keep_D(keep_D), .ctrl_D(ctrl_D),
        .data_E(data_E3), .keep_E(keep_E3), .ctrl_E(ctrl_E3),
        .valid_E(valid_E3), .bubble_E(bubble_E3)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
`endif
    );

    function automatic logic [159:0] rnd160();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_slot(input string nm, input slot_t act, input logic bub, input slot_t exp);
        checks++;
        if (act !== exp || bub !== ~exp.valid) begin
            errors++;
            $display("FAIL %s t=%0t: got v=%0b d=%h k=%h c=%h bub=%0b, expected v=%0b d=%h k=%h c=%h bub=%0b",
                     nm, $time, act.valid, act.data, act.keep, act.ctrl, bub,
                     exp.valid, exp.data, exp.keep, exp.ctrl, ~exp.valid);
        end
    endtask

    task automatic underflow(input string nm);
        checks++;
        errors++;
        $display("FAIL %s t=%0t: output advanced but no expected slot queued (got none, required one)", nm, $time);
    endtask

    task automatic check_all(input string tag);
        check_slot({"d1_", tag}, {valid_E1, data_E1, keep_E1, ctrl_E1}, bubble_E1, last1);
        check_slot({"d2_", tag}, {valid_E2, data_E2, keep_E2, ctrl_E2}, bubble_E2, last2);
        check_slot({"d3_", tag}, {valid_E3, data_E3, keep_E3, ctrl_E3}, bubble_E3, last3);
    endtask

    // Stimulus: drive one edge's inputs at the falling edge and enqueue what
    // enters the pipe. Reset refills each pipe with DEPTH empty slots.
    task automatic drive(input bit r, input bit s, input bit c, input bit v,
                         input logic [159:0] d, input logic [31:0] k, input logic [7:0] ct);
        slot_t sl;
        @(negedge clk);
        reset = r; stall = s; clr = c; valid_D = v;
        data_D = d; keep_D = k; ctrl_D = ct;
        $display("drive: reset=%0b stall=%0b clr=%0b valid=%0b keep=%h ctrl=%h", r, s, c, v, k, ct);
        if (r) begin
            q1.delete(); q2.delete(); q3.delete();
            q1.push_back('0);
            repeat (2) q2.push_back('0);
            repeat (3) q3.push_back('0);
        end else if (!s) begin
            sl = c ? slot_t'{1'b0, 160'd0, k, 8'd0} : slot_t'{v, d, k, ct};
            q1.push_back(sl); q2.push_back(sl); q3.push_back(sl);
        end
    endtask

    task automatic load_rnd(input bit s, input bit c);
        drive(1'b0, s, c, 1'($urandom_range(0, 1)), rnd160(), $urandom, 8'($urandom));
    endtask

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] exp_stall = '0, exp_flush = '0;
`endif

    // Monitor: one pop per advancing edge, hold otherwise; outputs are also
    // rechecked after inputs change mid-cycle to catch combinational paths.
    initial begin
        bit rs, ss, cs;
        forever begin
            @(posedge clk);
            rs = reset; ss = stall; cs = clr;
            #1;
            if (rs || !ss) begin
                if (q1.size() == 0) underflow("d1_queue"); else last1 = q1.pop_front();
                if (q2.size() == 0) underflow("d2_queue"); else last2 = q2.pop_front();
                if (q3.size() == 0) underflow("d3_queue"); else last3 = q3.pop_front();
            end
            check_all("edge");
`ifdef PIPE_STAGE_PERF_EN
            if (rs) begin
                exp_stall = '0; exp_flush = '0;
            end else begin
                if (ss && exp_stall != 32'hFFFF_FFFF) exp_stall++;
                if (cs && !ss && exp_flush != 32'hFFFF_FFFF) exp_flush++;
            end
            checks++;
            if (stall_cnt1 !== exp_stall || flush_cnt1 !== exp_flush) begin
                errors++;
                $display("FAIL perf_cnt: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                         stall_cnt1, flush_cnt1, exp_stall, exp_flush);
            end
`endif
            @(negedge clk);
            #2;
            check_all("midcycle");
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; clr = 1'b0; valid_D = 1'b0;
        data_D = '0; keep_D = '0; ctrl_D = '0;
        last1 = '0; last2 = '0; last3 = '0;
        // First edge is a reset edge.
        q1.push_back('0);
        repeat (2) q2.push_back('0);
        repeat (3) q3.push_back('0);
        // Power-up state before any edge.
        #1;
        check_all("powerup");

        drive(1, 0, 0, 0, '0, '0, '0);
        // Single load of a known pattern, then a bubble with PC+4 kept.
        drive(0, 0, 0, 1, {5{32'hA5A5_A5A5}}, 32'h0040_0004, 8'h01);
        drive(0, 0, 1, 1, rnd160(), 32'h0040_0010, 8'hFF);
        // Stream with a two-cycle stall in the middle.
        repeat (4) load_rnd(0, 0);
        repeat (2) load_rnd(1, 0);
        repeat (4) load_rnd(0, 0);
        // Stall together with clr: clr is dropped.
        repeat (2) load_rnd(1, 1);
        load_rnd(0, 0);
        // Fill the pipe, then reset while stalled, then resume.
        repeat (3) drive(0, 0, 0, 1, rnd160(), $urandom, 8'($urandom));
        drive(1, 1, 1, 1, rnd160(), $urandom, 8'($urandom));
        drive(0, 0, 0, 1, {5{32'h1234_5678}}, 32'h0040_0020, 8'h5A);
        repeat (3) load_rnd(0, 0);
        // Long stall run.
        repeat (6) load_rnd(1, 0);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 9) < 7),
                  rnd160(), $urandom, 8'($urandom));
        end
        repeat (5) drive(0, 0, 0, 0, '0, '0, '0);
        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
